matmul_stream_core: RTL and testbench

Parametrised successor to the fixed-size matmul datapath/control pair. Computes C[M][N] = A[M][k_len] x B[k_len][N], where k_len is selected at run time up to K. Operands stream in one k-step per beat over a valid/ready handshake, and each beat is accumulated as an outer product. The result is presented on a held valid/ready output port. It sits between the operand-fetch logic and the result writeback in the accelerator.

---
 rtl/matmul_stream_core.sv | 151 +++++++++++++++
 tb/tb_matmul_stream_core.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/matmul_stream_core.sv
// Streaming outer-product matrix multiplier: C[M][N] = A[M][k_len] x B[k_len][N].
// Define MATMUL_SAT_EN for saturating accumulation with a sticky ovf flag.
module matmul_stream_core #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int M      = 2,
  parameter int N      = 2,
  parameter int K      = 8,
  localparam int KW    = $clog2(K + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [M*DATA_W-1:0]    s_a,
  input  logic [N*DATA_W-1:0]    s_b,
  output logic                   c_valid,
  input  logic                   c_ready,
  output logic [M*N*ACC_W-1:0]   c_data,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf
);

  if (ACC_W < 2 * DATA_W) begin : g_acc_w_check
    $error("matmul_stream_core: ACC_W must be >= 2*DATA_W");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  localparam logic [KW-1:0] K_MAX = KW'(K);

`ifdef MATMUL_SAT_EN
  localparam int SUM_W = ACC_W + 1;
`else
  localparam int SUM_W = ACC_W;
`endif

  logic [1:0]              state;
  logic [KW-1:0]           k_lat;
  logic [KW-1:0]           count;
  logic signed [ACC_W-1:0] acc     [M][N];
  logic signed [ACC_W-1:0] acc_nxt [M][N];
  logic signed [2*DATA_W-1:0] prod;
  logic signed [SUM_W-1:0]    sum;
  logic                    beat;
  logic                    start_ok;
  logic [KW-1:0]           k_eff;
  logic                    ovf_hit;

  assign s_ready  = (state == S_ACCUM);
  assign c_valid  = (state == S_OUT);
  assign busy     = (state != S_IDLE);
  assign beat     = s_valid && s_ready;
  assign start_ok = start && (state == S_IDLE);
  assign k_eff    = (k_len > K_MAX) ? K_MAX : k_len;

  for (genvar gi = 0; gi < M; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      assign c_data[(gi*N+gj)*ACC_W +: ACC_W] = acc[gi][gj];
    end
  end

  // NOTE: every always_comb output gets a default before any conditional
  // assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    prod    = '0;
    sum     = '0;
    ovf_hit = 1'b0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        prod = $signed(s_a[i*DATA_W +: DATA_W]) * $signed(s_b[j*DATA_W +: DATA_W]);
        sum  = SUM_W'(acc[i][j]) + SUM_W'(prod);
`ifdef MATMUL_SAT_EN
        // The extra guard bit disagreeing with the sign bit means the sum left the ACC_W range.
        if (sum[ACC_W] != sum[ACC_W-1]) begin
          acc_nxt[i][j] = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
          ovf_hit       = 1'b1;
        end else begin
          acc_nxt[i][j] = sum[ACC_W-1:0];
        end
`else
        acc_nxt[i][j] = sum;
`endif
      end
    end
  end

  // NOTE: state registers use non-blocking (<=) assignments so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: the accumulator array is reset because c_data reads it directly and
  // must show zero out of reset; it is a register bank, not a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      k_lat <= '0;
      count <= '0;
      done  <= 1'b0;
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++)
          acc[i][j] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            k_lat <= k_eff;
            count <= '0;
            for (int i = 0; i < M; i++)
              for (int j = 0; j < N; j++)
                acc[i][j] <= '0;
            state <= (k_eff != '0) ? S_ACCUM : S_OUT;
          end
        end
        S_ACCUM: begin
          if (beat) begin
            acc   <= acc_nxt;
            count <= count + 1'b1;
            if (count == k_lat - 1'b1) state <= S_OUT;
          end
        end
        S_OUT: begin
          if (c_ready) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MATMUL_SAT_EN
  logic ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                ovf_q <= 1'b0;
    else if (start_ok)      ovf_q <= 1'b0;
    else if (beat && ovf_hit) ovf_q <= 1'b1;
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
  logic unused_ovf_hit;
  assign unused_ovf_hit = ovf_hit;
`endif

endmodule

// File: tb/tb_matmul_stream_core.sv
// Directed, table-driven bench for matmul_stream_core (M=N=2, DATA_W=16, ACC_W=32, K=8).
module tb_matmul_stream_core;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int M      = 2;
  localparam int N      = 2;
  localparam int K      = 8;
  localparam int KW     = $clog2(K + 1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [KW-1:0]        k_len;
  logic                 s_valid;
  logic                 s_ready;
  logic [M*DATA_W-1:0]  s_a;
  logic [N*DATA_W-1:0]  s_b;
  logic                 c_valid;
  logic                 c_ready;
  logic [M*N*ACC_W-1:0] c_data;
  logic                 busy;
  logic                 done;
  logic                 ovf;

  int n_tests = 0;
  int n_fail  = 0;

  matmul_stream_core #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .M(M), .N(N), .K(K)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
    .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string           name;
    int              k;
    int              beats;
    bit              toggle;
    logic [7:0][31:0] a;
    logic [7:0][31:0] b;
    logic [3:0][31:0] c;
    bit              exp_ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pk(input int x0, input int x1);
    logic [15:0] h0, h1;
    h0 = 16'(x0);
    h1 = 16'(x1);
    return {h1, h0};
  endfunction

  function automatic vec_t mk(input string name, input int k, input int beats, input bit tog,
                              input int a0, input int a1, input int b0, input int b1,
                              input int c0, input int c1, input int c2, input int c3,
                              input bit exp_ovf);
    vec_t v;
    v.name = name; v.k = k; v.beats = beats; v.toggle = tog; v.exp_ovf = exp_ovf;
    for (int i = 0; i < 8; i++) begin
      v.a[i] = pk(a0, a1);
      v.b[i] = pk(b0, b1);
    end
    v.c[0] = 32'(c0); v.c[1] = 32'(c1); v.c[2] = 32'(c2); v.c[3] = 32'(c3);
    return v;
  endfunction

  task automatic check_c(input string name, input vec_t v);
    for (int e = 0; e < 4; e++)
      check($sformatf("%s c[%0d]", name, e), $signed(c_data[e*ACC_W +: ACC_W]), $signed(v.c[e]));
  endtask

  // Runs one product from start to done with c_ready held high.
  task automatic run_vec(input vec_t v);
    start = 1'b1; k_len = KW'(v.k); c_ready = 1'b1;
    step();
    start = 1'b0;
    check({v.name, " busy"}, busy, 1);
    for (int b = 0; b < v.beats; b++) begin
      s_valid = 1'b1; s_a = v.a[b]; s_b = v.b[b];
      if (b == 0) check({v.name, " s_ready"}, s_ready, 1);
      step();
      if (v.toggle && b != v.beats - 1) begin
        s_valid = 1'b0; s_a = 32'h7fff_7fff; s_b = 32'h7fff_7fff;
        step();
      end
    end
    s_valid = 1'b0;
    check({v.name, " c_valid"}, c_valid, 1);
    check({v.name, " s_ready in OUT"}, s_ready, 0);
    check_c(v.name, v);
    check({v.name, " ovf"}, ovf, v.exp_ovf);
    step();
    check({v.name, " done"}, done, 1);
    check({v.name, " idle"}, busy, 0);
    step();
    check({v.name, " done pulse"}, done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; s_valid = 1'b0;
    s_a = '0; s_b = '0; c_ready = 1'b0;

    vecs[0] = mk("basic2x2", 2, 2, 0, 0, 0, 0, 0, 19, 22, 43, 50, 0);
    vecs[0].a[0] = pk(1, 3); vecs[0].a[1] = pk(2, 4);
    vecs[0].b[0] = pk(5, 6); vecs[0].b[1] = pk(7, 8);
    vecs[1] = mk("toggle_neg", 5, 5, 1, -3, -3, 2, 2, -30, -30, -30, -30, 0);
    vecs[2] = mk("k0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3] = mk("k9_clamp", 9, 8, 0, 1, 2, 3, 4, 24, 32, 48, 64, 0);
    vecs[4] = mk("mixed", 3, 3, 0, -1, 5, 7, -2, -21, 6, 105, -30, 0);
`ifdef MATMUL_SAT_EN
    vecs[5] = mk("overflow", 4, 4, 0, 32767, 32767, 32767, 32767,
                 2147483647, 2147483647, 2147483647, 2147483647, 1);
`else
    vecs[5] = mk("overflow", 4, 4, 0, 32767, 32767, 32767, 32767,
                 -262140, -262140, -262140, -262140, 0);
`endif
    vecs[6] = mk("after_abort", 1, 1, 0, 2, 3, 4, 5, 8, 10, 12, 15, 0);

    // Reset state
    step(); step();
    check("rst s_ready", s_ready, 0);
    check("rst c_valid", c_valid, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst ovf", ovf, 0);
    check("rst c_data", c_data[63:0], 0);
    rst = 1'b0;
    step();

    for (int t = 0; t < 6; t++) run_vec(vecs[t]);

    // Held output: c_ready low for 10 cycles, start pulses ignored
    start = 1'b1; k_len = KW'(1); c_ready = 1'b0;
    step();
    start = 1'b0; s_valid = 1'b1; s_a = pk(1, 1); s_b = pk(1, 1);
    step();
    s_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      start = c[0]; k_len = KW'(3);
      step();
      check($sformatf("hold c_valid %0d", c), c_valid, 1);
      check($sformatf("hold c_data %0d", c), $signed(c_data[ACC_W-1:0]), 1);
    end
    check("hold c11", $signed(c_data[3*ACC_W +: ACC_W]), 1);
    start = 1'b0; c_ready = 1'b1;
    step();
    check("hold done", done, 1);
    // Back-to-back: start accepted in the done cycle
    start = 1'b1; k_len = '0;
    step();
    start = 1'b0;
    check("b2b c_valid", c_valid, 1);
    check("b2b c_data", c_data[63:0], 0);
    step();
    check("b2b done", done, 1);
    step();

    // Reset mid-product, then a clean product
    start = 1'b1; k_len = KW'(4);
    step();
    start = 1'b0; s_valid = 1'b1; s_a = pk(9, 9); s_b = pk(9, 9);
    step(); step();
    s_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort s_ready", s_ready, 0);
    check("abort c_valid", c_valid, 0);
    check("abort c_data", c_data[63:0], 0);
    step();
    rst = 1'b0;
    step();
    check("abort no done", done, 0);
    run_vec(vecs[6]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
